// File: rtl/multicycle_control_unit.sv
// Control FSM for the miniMIPS multi-cycle datapath: sequences fetch/decode/execute/
// memory/write-back, drives every datapath enable and select, and counts retired instructions.
module multicycle_control_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               pc_wr_cond,
  output logic               branch_ne,
  output logic               pc_src,
  output logic               i_or_d,
  output logic               ir_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_dest,
  output logic               mem_to_reg,
  output logic               reg_wr,
  output logic               alusrc_a,
  output logic [1:0]         alusrc_b,
  output logic [2:0]         alu_op,
  output logic               illegal_op,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       branch_ne;
    logic       pc_src;
    logic       i_or_d;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  state_t             r_state;
  state_t             w_next;
  ctrl_t              w_ctrl;
  ctrl_t              w_out;
  logic               w_retire;
  logic [2:0]         w_imm_alu_op;
  logic [COUNT_W-1:0] r_retired;
  logic               w_unused;

  // The branch decision is made in the datapath from zero and pc_wr_cond/branch_ne.
  assign w_unused = zero;

  always_comb begin
    w_imm_alu_op = 3'b000;
    case (opcode)
      4'b0001: w_imm_alu_op = 3'b000;
      4'b0010: w_imm_alu_op = 3'b011;
      4'b0011: w_imm_alu_op = 3'b100;
      4'b0100: w_imm_alu_op = 3'b101;
      4'b0111: w_imm_alu_op = 3'b110;
      default: w_imm_alu_op = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ctrl   = '0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_rd   = 1'b1;
        w_ctrl.alusrc_b = 2'b01;
        if (mem_ready) begin
          w_ctrl.ir_wr = 1'b1;
          w_ctrl.pc_wr = 1'b1;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        w_ctrl.alusrc_b = 2'b10;
        case (opcode)
          4'b0000:                   w_next = S_EXEC_R;
          4'b1000, 4'b1001:          w_next = S_MEM_ADDR;
          4'b0101, 4'b0110:          w_next = S_BRANCH;
          4'b0001, 4'b0010, 4'b0011,
          4'b0100, 4'b0111:          w_next = S_EXEC_I;
          default: begin
            w_ctrl.illegal_op = 1'b1;
            w_next            = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_ctrl.alusrc_a = 1'b1;
        w_ctrl.alusrc_b = 2'b10;
        w_next          = (opcode == 4'b1001) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_ctrl.mem_rd = 1'b1;
        w_ctrl.i_or_d = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_ctrl.reg_wr     = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_retire          = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_wr = 1'b1;
        w_ctrl.i_or_d = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        w_ctrl.alusrc_a = 1'b1;
        w_ctrl.alu_op   = 3'b010;
        w_next          = S_R_WB;
      end
      S_R_WB: begin
        w_ctrl.reg_wr   = 1'b1;
        w_ctrl.reg_dest = 1'b1;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_EXEC_I: begin
        w_ctrl.alusrc_a = 1'b1;
        w_ctrl.alusrc_b = 2'b10;
        w_ctrl.alu_op   = w_imm_alu_op;
        w_next          = S_I_WB;
      end
      S_I_WB: begin
        // Opcode is still stable in IR, so the EXEC_I operation is simply re-decoded.
        w_ctrl.reg_wr = 1'b1;
        w_ctrl.alu_op = w_imm_alu_op;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alusrc_a   = 1'b1;
        w_ctrl.alu_op     = 3'b001;
        w_ctrl.pc_wr_cond = 1'b1;
        w_ctrl.pc_src     = 1'b1;
        w_ctrl.branch_ne  = (opcode == 4'b0110);
        w_retire          = 1'b1;
        w_next            = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + {{(COUNT_W-1){1'b0}}, 1'b1};
  end

  // Strobes are blanked for the whole time reset is held, not just after the clock edge.
  assign w_out = reset ? ctrl_t'('0) : w_ctrl;

  assign pc_wr         = w_out.pc_wr;
  assign pc_wr_cond    = w_out.pc_wr_cond;
  assign branch_ne     = w_out.branch_ne;
  assign pc_src        = w_out.pc_src;
  assign i_or_d        = w_out.i_or_d;
  assign ir_wr         = w_out.ir_wr;
  assign mem_rd        = w_out.mem_rd;
  assign mem_wr        = w_out.mem_wr;
  assign reg_dest      = w_out.reg_dest;
  assign mem_to_reg    = w_out.mem_to_reg;
  assign reg_wr        = w_out.reg_wr;
  assign alusrc_a      = w_out.alusrc_a;
  assign alusrc_b      = w_out.alusrc_b;
  assign alu_op        = w_out.alu_op;
  assign illegal_op    = w_out.illegal_op;
  assign state         = r_state;
  assign instr_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle state/control-word checks against
// hand-computed constants, retire counting, async reset and counter wrap (narrow instance).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_wr, pc_wr_cond, branch_ne, pc_src, i_or_d, ir_wr, mem_rd, mem_wr;
  logic        reg_dest, mem_to_reg, reg_wr, alusrc_a, illegal_op;
  logic [1:0]  alusrc_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [15:0] instr_retired;

  logic        s_pc_wr, s_pc_wr_cond, s_branch_ne, s_pc_src, s_i_or_d, s_ir_wr, s_mem_rd, s_mem_wr;
  logic        s_reg_dest, s_mem_to_reg, s_reg_wr, s_alusrc_a, s_illegal_op;
  logic [1:0]  s_alusrc_b;
  logic [2:0]  s_alu_op;
  logic [3:0]  s_state;
  logic [2:0]  s_retired;

  logic [17:0] w_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_retired = 0;

  // {pc_wr,pc_wr_cond,branch_ne,pc_src,i_or_d,ir_wr,mem_rd,mem_wr,reg_dest,mem_to_reg,
  //  reg_wr,alusrc_a,alusrc_b[1:0],alu_op[2:0],illegal_op}
  localparam logic [17:0] CW_FETCH_WAIT = 18'h00810;
  localparam logic [17:0] CW_FETCH_GO   = 18'h21810;
  localparam logic [17:0] CW_DECODE     = 18'h00020;
  localparam logic [17:0] CW_DECODE_ILL = 18'h00021;
  localparam logic [17:0] CW_MEM_ADDR   = 18'h00060;
  localparam logic [17:0] CW_MEM_READ   = 18'h02800;
  localparam logic [17:0] CW_MEM_WB     = 18'h00180;
  localparam logic [17:0] CW_MEM_WRITE  = 18'h02400;
  localparam logic [17:0] CW_EXEC_R     = 18'h00044;
  localparam logic [17:0] CW_R_WB       = 18'h00280;
  localparam logic [17:0] CW_BEQ        = 18'h14042;
  localparam logic [17:0] CW_BNE        = 18'h1C042;

  logic [3:0]  imm_op [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111};
  logic [17:0] imm_ex [5] = '{18'h00060, 18'h00066, 18'h00068, 18'h0006A, 18'h0006C};
  logic [17:0] imm_wb [5] = '{18'h00080, 18'h00086, 18'h00088, 18'h0008A, 18'h0008C};

  multicycle_control_unit #(.COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .branch_ne(branch_ne), .pc_src(pc_src),
    .i_or_d(i_or_d), .ir_wr(ir_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state), .instr_retired(instr_retired)
  );

  // Narrow-counter instance runs in lockstep so the wrap to zero is reachable quickly.
  multicycle_control_unit #(.COUNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(s_pc_wr), .pc_wr_cond(s_pc_wr_cond), .branch_ne(s_branch_ne), .pc_src(s_pc_src),
    .i_or_d(s_i_or_d), .ir_wr(s_ir_wr), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
    .reg_dest(s_reg_dest), .mem_to_reg(s_mem_to_reg), .reg_wr(s_reg_wr), .alusrc_a(s_alusrc_a),
    .alusrc_b(s_alusrc_b), .alu_op(s_alu_op), .illegal_op(s_illegal_op), .state(s_state),
    .instr_retired(s_retired)
  );

  assign w_ctrl = {pc_wr, pc_wr_cond, branch_ne, pc_src, i_or_d, ir_wr, mem_rd, mem_wr,
                   reg_dest, mem_to_reg, reg_wr, alusrc_a, alusrc_b, alu_op, illegal_op};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive mem_ready for this cycle, check state and control word mid-cycle, then advance.
  task automatic step(input string tag, input logic mr, input logic [3:0] st,
                      input logic [17:0] cw);
    mem_ready = mr;
    #1;
    check_eq({tag, "_state"}, {28'd0, state}, {28'd0, st});
    check_eq({tag, "_ctrl"}, {14'd0, w_ctrl}, {14'd0, cw});
    @(posedge clk);
    #1;
  endtask

  task automatic check_retired(input string tag);
    check_eq({tag, "_ret"}, {16'd0, instr_retired}, exp_retired & 32'hFFFF);
    check_eq({tag, "_ret3"}, {29'd0, s_retired}, exp_retired & 32'h7);
  endtask

  task automatic do_rtype(input string tag);
    opcode = 4'b0000;
    step({tag, "_f"}, 1'b1, 4'd0, CW_FETCH_GO);
    step({tag, "_d"}, 1'b0, 4'd1, CW_DECODE);
    step({tag, "_x"}, 1'b1, 4'd6, CW_EXEC_R);
    step({tag, "_w"}, 1'b0, 4'd7, CW_R_WB);
    exp_retired++;
    check_retired(tag);
  endtask

  task automatic do_lw(input string tag, input int stalls);
    opcode = 4'b1000;
    step({tag, "_f"}, 1'b1, 4'd0, CW_FETCH_GO);
    step({tag, "_d"}, 1'b1, 4'd1, CW_DECODE);
    step({tag, "_a"}, 1'b1, 4'd2, CW_MEM_ADDR);
    for (int i = 0; i < stalls; i++) step({tag, "_rs"}, 1'b0, 4'd3, CW_MEM_READ);
    step({tag, "_r"}, 1'b1, 4'd3, CW_MEM_READ);
    step({tag, "_w"}, 1'b0, 4'd4, CW_MEM_WB);
    exp_retired++;
    check_retired(tag);
  endtask

  task automatic do_sw(input string tag);
    opcode = 4'b1001;
    step({tag, "_fs"}, 1'b0, 4'd0, CW_FETCH_WAIT);
    step({tag, "_f"}, 1'b1, 4'd0, CW_FETCH_GO);
    step({tag, "_d"}, 1'b0, 4'd1, CW_DECODE);
    step({tag, "_a"}, 1'b0, 4'd2, CW_MEM_ADDR);
    step({tag, "_m"}, 1'b1, 4'd5, CW_MEM_WRITE);
    exp_retired++;
    check_retired(tag);
  endtask

  task automatic do_branch(input string tag, input logic [3:0] op, input logic [17:0] cw);
    opcode = op;
    step({tag, "_f"}, 1'b1, 4'd0, CW_FETCH_GO);
    step({tag, "_d"}, 1'b1, 4'd1, CW_DECODE);
    step({tag, "_b"}, 1'b1, 4'd10, cw);
    exp_retired++;
    check_retired(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check_eq("rst_state", {28'd0, state}, 32'd0);
    check_eq("rst_ctrl", {14'd0, w_ctrl}, 32'd0);
    check_retired("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    do_rtype("rtype");
    do_lw("lw", 2);
    do_sw("sw");
    do_branch("bne", 4'b0110, CW_BNE);
    do_branch("beq", 4'b0101, CW_BEQ);

    for (int i = 0; i < 5; i++) begin
      opcode = imm_op[i];
      step($sformatf("imm%0d_f", i), 1'b1, 4'd0, CW_FETCH_GO);
      step($sformatf("imm%0d_d", i), 1'b0, 4'd1, CW_DECODE);
      step($sformatf("imm%0d_x", i), 1'b0, 4'd8, imm_ex[i]);
      step($sformatf("imm%0d_w", i), 1'b1, 4'd9, imm_wb[i]);
      exp_retired++;
      check_retired($sformatf("imm%0d", i));
    end

    opcode = 4'b1100;
    step("ill_f", 1'b1, 4'd0, CW_FETCH_GO);
    step("ill_d", 1'b1, 4'd1, CW_DECODE_ILL);
    step("ill_after", 1'b0, 4'd0, CW_FETCH_WAIT);
    check_retired("ill");
    opcode = 4'b1111;
    step("ill2_f", 1'b1, 4'd0, CW_FETCH_GO);
    step("ill2_d", 1'b0, 4'd1, CW_DECODE_ILL);
    check_retired("ill2");

    // Reset in the middle of a stalled load read.
    opcode = 4'b1000;
    step("rmr_f", 1'b1, 4'd0, CW_FETCH_GO);
    step("rmr_d", 1'b0, 4'd1, CW_DECODE);
    step("rmr_a", 1'b0, 4'd2, CW_MEM_ADDR);
    mem_ready = 1'b0;
    #1;
    check_eq("rmr_wait_state", {28'd0, state}, 32'd3);
    #1;
    reset = 1'b1;
    #1;
    exp_retired = 0;
    check_eq("rmr_async_state", {28'd0, state}, 32'd0);
    check_eq("rmr_async_ctrl", {14'd0, w_ctrl}, 32'd0);
    check_retired("rmr_async");
    @(posedge clk); #1;
    check_eq("rmr_hold_ctrl", {14'd0, w_ctrl}, 32'd0);
    reset = 1'b0;
    step("rmr_rel", 1'b0, 4'd0, CW_FETCH_WAIT);
    check_retired("rmr_rel");

    // Drive the 3-bit counter through all-ones and back to zero.
    for (int i = 0; i < 7; i++) do_branch($sformatf("wrap%0d", i), 4'b0101, CW_BEQ);
    check_eq("wrap_pre", {29'd0, s_retired}, 32'd7);
    do_branch("wrap7", 4'b0110, CW_BNE);
    check_eq("wrap_zero", {29'd0, s_retired}, 32'd0);
    check_eq("wrap_main", {16'd0, instr_retired}, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
